// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect input and decode handshake.
interface fetch_unit_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]       imem_addr;
  logic [DWIDTH-1:0] imem_instr;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              dec_valid;
  logic              dec_ready;
  logic [DWIDTH-1:0] dec_instr;
  logic [31:0]       dec_pc;
  logic [CW-1:0]     q_count;

  // Environment view: memory, execute and decode around the fetch unit.
  modport master (
    input  imem_addr, dec_valid, dec_instr, dec_pc, q_count,
    output imem_instr, redirect_valid, redirect_pc, dec_ready
  );

  // Fetch unit view.
  modport slave (
    output imem_addr, dec_valid, dec_instr, dec_pc, q_count,
    input  imem_instr, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, queues {pc, instr} pairs for decode,
// and flushes/restarts on redirects from execute.
module fetch_unit #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          nrst,
  fetch_unit_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]       pc;
  logic [31:0]       q_pc    [DEPTH];
  logic [DWIDTH-1:0] q_instr [DEPTH];
  logic [AW-1:0]     rptr;
  logic [AW-1:0]     wptr;
  logic [CW-1:0]     count;
  logic              pop_c;
  logic              push_c;
  logic              unused_redirect_lsbs_c;

  // Redirect suppresses both queue operations; a full queue still fetches when the head retires.
  always_comb begin
    pop_c  = 1'b0;
    push_c = 1'b0;
    if (!bus.redirect_valid) begin
      pop_c  = (count != '0) && bus.dec_ready;
      push_c = (count < CW'(DEPTH)) || pop_c;
    end
  end

  // PC, pointers and occupancy; reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pc    <= RESET_PC;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (bus.redirect_valid) begin
      pc    <= {bus.redirect_pc[31:2], 2'b00};
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push_c) begin
        pc   <= pc + 32'd4;
        wptr <= wptr + AW'(1);
      end
      if (pop_c) begin
        rptr <= rptr + AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; stale contents are harmless because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_c) begin
      q_pc[wptr]    <= pc;
      q_instr[wptr] <= bus.imem_instr;
    end
  end

  assign bus.imem_addr  = {2'b00, pc[31:2]};
  assign bus.dec_valid  = (count != '0);
  assign bus.dec_pc     = q_pc[rptr];
  assign bus.dec_instr  = q_instr[rptr];
  assign bus.q_count    = count;

  assign unused_redirect_lsbs_c = ^bus.redirect_pc[1:0];
endmodule
